// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared defaults, window FSM states and sample rounding helper.
// Revision : 1.0
// ============================================================================
package fir_pkg;

  localparam int NTAPS_DEF   = 64;
  localparam int IN_W_DEF    = 24;
  localparam int DATA_W_DEF  = 16;
  localparam int ROUND_MAX_W = 32;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    PRESENT = 2'd2,
    BUSY    = 2'd3
  } win_state_t;

  // Round half up on a width-bit signed field, saturating only at the
  // positive rail; the caller keeps the low width bits of the result.
  function automatic logic [ROUND_MAX_W-1:0] round_sat(
    input logic [ROUND_MAX_W-1:0] field,
    input logic                   round_bit,
    input int                     width
  );
    logic [ROUND_MAX_W-1:0] max_pos;
    max_pos = (ROUND_MAX_W'(1) << (width - 1)) - ROUND_MAX_W'(1);
    if ((field == max_pos) && round_bit) begin
      return max_pos;
    end
    return field + ROUND_MAX_W'(round_bit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_window_ram.sv
`default_nettype none
// ============================================================================
// Module   : fir_window_ram
// Brief    : Simple dual-port 1W/1R sample RAM with registered read port.
// Revision : 1.0
// ============================================================================
module fir_window_ram #(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // Storage has no reset so it can map onto block RAM; only the output
  // register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fir_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fir_window_buffer
// Brief    : Circular sample window for the FIR MAC engine, with freeze
//            handshake, one-deep skid register and sticky overrun flag.
// Revision : 1.0
// ============================================================================
module fir_window_buffer
  import fir_pkg::*;
#(
  parameter  int NTAPS  = NTAPS_DEF,
  parameter  int IN_W   = IN_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int IDX_W  = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   sample_in,
  input  logic              sample_valid,
  output logic              win_valid,
  input  logic              win_ack,
  input  logic              fir_done,
  input  logic [IDX_W-1:0]  tap_idx,
  output logic [DATA_W-1:0] tap_sample,
  output logic              overrun,
  input  logic              overrun_clr
);

  win_state_t        state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  newest_ptr_q, newest_ptr_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              overrun_q, overrun_d;
  logic              win_valid_q, win_valid_d;
  logic              overrun_set;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [IDX_W-1:0]  tap_addr;

  logic [DATA_W-1:0] top_field;
  logic              round_bit;
  logic [DATA_W-1:0] conv_sample;

  assign top_field   = sample_in[IN_W-1 -: DATA_W];
  assign round_bit   = sample_in[IN_W-DATA_W-1];
  assign conv_sample = DATA_W'(round_sat(ROUND_MAX_W'(top_field), round_bit, DATA_W));

  generate
    if (IN_W - DATA_W >= 2) begin : g_unused_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^sample_in[IN_W-DATA_W-2:0];
    end
  endgenerate

  // Tap 0 is the newest sample; older taps walk backwards around the ring.
  assign tap_addr = newest_ptr_q - tap_idx;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    newest_ptr_d = newest_ptr_q;
    clr_cnt_d    = clr_cnt_q;
    pend_v_d     = pend_v_q;
    pend_data_d  = pend_data_q;
    overrun_set  = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q;
    ram_wdata    = conv_sample;

    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(NTAPS - 1)) begin
          state_d = IDLE;
        end
        if (sample_valid) begin
          overrun_set = 1'b1;
        end
      end
      IDLE: begin
        if (sample_valid) begin
          ram_we       = 1'b1;
          newest_ptr_d = wr_ptr_q;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          state_d      = PRESENT;
        end
      end
      PRESENT: begin
        if (sample_valid) begin
          if (pend_v_q) begin
            overrun_set = 1'b1;
          end else begin
            pend_v_d    = 1'b1;
            pend_data_d = conv_sample;
          end
        end
        if (win_ack) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (fir_done) begin
          state_d = PRESENT;
          if (pend_v_q) begin
            // Parked sample commits first; a simultaneous arrival takes its slot.
            ram_we       = 1'b1;
            ram_wdata    = pend_data_q;
            newest_ptr_d = wr_ptr_q;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            if (sample_valid) begin
              pend_data_d = conv_sample;
            end else begin
              pend_v_d = 1'b0;
            end
          end else if (sample_valid) begin
            ram_we       = 1'b1;
            newest_ptr_d = wr_ptr_q;
            wr_ptr_d     = wr_ptr_q + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (sample_valid) begin
          if (pend_v_q) begin
            overrun_set = 1'b1;
          end else begin
            pend_v_d    = 1'b1;
            pend_data_d = conv_sample;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    overrun_d   = (overrun_q & ~overrun_clr) | overrun_set;
    win_valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      wr_ptr_q     <= '0;
      newest_ptr_q <= '0;
      clr_cnt_q    <= '0;
      pend_v_q     <= 1'b0;
      pend_data_q  <= '0;
      overrun_q    <= 1'b0;
      win_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      newest_ptr_q <= newest_ptr_d;
      clr_cnt_q    <= clr_cnt_d;
      pend_v_q     <= pend_v_d;
      pend_data_q  <= pend_data_d;
      overrun_q    <= overrun_d;
      win_valid_q  <= win_valid_d;
    end
  end

  fir_window_ram #(
    .DEPTH  (NTAPS),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (tap_addr),
    .rd_data (tap_sample)
  );

  assign win_valid = win_valid_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_window_buffer
// Brief    : Directed self-checking bench for fir_window_buffer.
// Revision : 1.0
// ============================================================================
module tb_fir_window_buffer;

  localparam int NTAPS  = 64;
  localparam int IN_W   = 24;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [IN_W-1:0]   sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              win_valid;
  logic              win_ack = 1'b0;
  logic              fir_done = 1'b0;
  logic [IDX_W-1:0]  tap_idx = '0;
  logic [DATA_W-1:0] tap_sample;
  logic              overrun;
  logic              overrun_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_window_buffer #(
    .NTAPS  (NTAPS),
    .IN_W   (IN_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .win_valid    (win_valid),
    .win_ack      (win_ack),
    .fir_done     (fir_done),
    .tap_idx      (tap_idx),
    .tap_sample   (tap_sample),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_vec("rst_win_valid", 32'(win_valid), 32'd0);
    check_vec("rst_overrun", 32'(overrun), 32'd0);
    check_vec("rst_tap_sample", 32'(tap_sample), 32'd0);
    reset = 1'b0;
  endtask

  // Runs through the clear phase; optionally injects one sample mid-clear.
  task automatic run_clear(input bit inject);
    bit wv_seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (win_valid) wv_seen = 1'b1;
      if (inject && i == 10) begin
        sample_in    = 24'h111100;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
    end
    check_vec("clear_win_valid_low", 32'(wv_seen), 32'd0);
  endtask

  task automatic send_sample(input logic [IN_W-1:0] v);
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    win_ack = 1'b1;
    @(negedge clk);
    win_ack = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    fir_done = 1'b1;
    @(negedge clk);
    fir_done = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic check_tap(input string tag, input int idx, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    tap_idx = IDX_W'(idx);
    @(negedge clk);
    check_vec(tag, 32'(tap_sample), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    run_clear(1'b1);
    check_vec("clear_drop_overrun", 32'(overrun), 32'd1);
    pulse_clr();
    check_vec("overrun_clr", 32'(overrun), 32'd0);

    // Rounding and saturation on three hand-picked samples.
    send_sample(24'h123480);
    check_vec("latency_win_valid", 32'(win_valid), 32'd1);
    pulse_ack();
    check_vec("ack_drops_win_valid", 32'(win_valid), 32'd0);
    pulse_done();
    send_sample(24'h7FFFFF);
    pulse_ack();
    pulse_done();
    send_sample(24'h80007F);
    check_tap("conv_tap0", 0, 16'h8000);
    check_tap("conv_tap1_sat", 1, 16'h7FFF);
    check_tap("conv_tap2_round", 2, 16'h1235);
    check_tap("conv_tap3_empty", 3, 16'h0000);
    pulse_ack();
    pulse_done();

    // Wrap the ring: 70 samples of value n.
    for (int n = 1; n <= 70; n++) begin
      send_sample(24'(n << 8));
      if (n < 70) begin
        pulse_ack();
        pulse_done();
      end
    end
    check_tap("wrap_tap0", 0, 16'd70);
    check_tap("wrap_tap1", 1, 16'd69);
    check_tap("wrap_tap62", 62, 16'd8);
    check_tap("wrap_tap63", 63, 16'd7);

    // Skid register and overrun while busy.
    pulse_ack();
    send_sample(24'h000A00);
    send_sample(24'h000B00);
    check_vec("busy_overrun", 32'(overrun), 32'd1);
    check_vec("busy_win_valid", 32'(win_valid), 32'd0);
    check_tap("busy_frozen_tap0", 0, 16'd70);
    pulse_done();
    check_vec("pend_present", 32'(win_valid), 32'd1);
    check_tap("pend_tap0", 0, 16'h000A);
    check_tap("pend_tap1", 1, 16'd70);
    pulse_clr();
    check_vec("overrun_cleared", 32'(overrun), 32'd0);

    // Set beats clear in the same cycle.
    send_sample(24'h000C00);
    @(negedge clk);
    sample_in    = 24'h000D00;
    sample_valid = 1'b1;
    overrun_clr  = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    overrun_clr  = 1'b0;
    check_vec("set_wins_clr", 32'(overrun), 32'd1);
    pulse_ack();
    pulse_done();
    check_tap("pend_present_tap0", 0, 16'h000C);
    pulse_clr();

    // fir_done with a simultaneous sample and nothing pending.
    pulse_ack();
    @(negedge clk);
    fir_done     = 1'b1;
    sample_in    = 24'h001100;
    sample_valid = 1'b1;
    @(negedge clk);
    fir_done     = 1'b0;
    sample_valid = 1'b0;
    check_vec("done_sv_win_valid", 32'(win_valid), 32'd1);
    check_vec("done_sv_overrun", 32'(overrun), 32'd0);
    check_tap("done_sv_tap0", 0, 16'h0011);
    check_tap("done_sv_tap1", 1, 16'h000C);

    // fir_done with pending and a simultaneous sample.
    pulse_ack();
    send_sample(24'h002200);
    @(negedge clk);
    fir_done     = 1'b1;
    sample_in    = 24'h003300;
    sample_valid = 1'b1;
    @(negedge clk);
    fir_done     = 1'b0;
    sample_valid = 1'b0;
    check_vec("swap_overrun", 32'(overrun), 32'd0);
    check_tap("swap_tap0", 0, 16'h0022);
    pulse_ack();
    pulse_done();
    check_vec("swap2_win_valid", 32'(win_valid), 32'd1);
    check_tap("swap2_tap0", 0, 16'h0033);
    check_tap("swap2_tap1", 1, 16'h0022);

    // Reset while busy with a parked sample.
    pulse_ack();
    send_sample(24'h004400);
    do_reset();
    run_clear(1'b0);
    check_vec("post_rst_overrun", 32'(overrun), 32'd0);
    send_sample(24'h005500);
    check_vec("post_rst_win_valid", 32'(win_valid), 32'd1);
    check_tap("post_rst_tap0", 0, 16'h0055);
    check_tap("post_rst_tap1", 1, 16'h0000);
    check_tap("post_rst_tap32", 32, 16'h0000);
    check_tap("post_rst_tap63", 63, 16'h0000);
    pulse_ack();
    pulse_done();
    check_vec("post_rst_pend_discarded", 32'(win_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
